// File: rtl/a0_trace_fifo.sv
// rtl/a0_trace_fifo.sv - change-detecting FWFT trace FIFO for the core's a0 result
// Queues each new a0 value; drops on overflow and counts drops instead of stalling the core.
module a0_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a0_in,
  input  logic                     capture_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0] last_a0_q, last_a0_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_req, pop, push, drop, mem_we;

  assign out_valid    = (level_q != '0);
  assign full         = (level_q == LW'(DEPTH));
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  // Storage is not reset, so gate the head with valid to keep out_data at 0 when empty.
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    last_a0_d = last_a0_q;
    primed_d  = primed_q;
    mem_we    = 1'b0;

    push_req = capture_en & (~primed_q | (a0_in != last_a0_q));
    pop      = out_valid & out_ready;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      primed_d = 1'b0;
    end else begin
      if (push_req) begin
        last_a0_d = a0_in;
        primed_d  = 1'b1;
      end
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(push) - LW'(pop);
      if (drop && (ovf_q != {CNT_W{1'b1}})) begin
        ovf_d = ovf_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= '0;
      last_a0_q <= '0;
      primed_q  <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      last_a0_q <= last_a0_d;
      primed_q  <= primed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= a0_in;
    end
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// tb/tb_a0_trace_fifo.sv - directed and randomized checks of a0_trace_fifo against a queue model
module tb_a0_trace_fifo;

  localparam int W = 32;
  localparam int D = 8;
  localparam int C = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     a0_in;
  logic             capture_en;
  logic             flush;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       level;
  logic             full;
  logic [C-1:0]     overflow_cnt;

  a0_trace_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .a0_in(a0_in), .capture_en(capture_en), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq [$];
  logic [W-1:0] m_last;
  bit           m_primed;
  int           m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = '0;
    m_primed = 1'b0;
    m_ovf    = 0;
  endtask

  // Behavioural rules applied to the queue with the inputs present at the edge.
  task automatic model_step();
    bit req, pp;
    if (flush) begin
      mq.delete();
      m_primed = 1'b0;
    end else begin
      req = capture_en && (!m_primed || a0_in != m_last);
      pp  = (mq.size() > 0) && out_ready;
      if (req) begin
        m_last   = a0_in;
        m_primed = 1'b1;
      end
      if (req && mq.size() == D && !pp) begin
        if (m_ovf < (1 << C) - 1) m_ovf++;
      end
      if (pp) void'(mq.pop_front());
      if (req && (mq.size() < D)) mq.push_back(a0_in);
    end
  endtask

  task automatic check_state();
    check("out_valid", out_valid, mq.size() != 0);
    check("level", level, mq.size());
    check("full", full, mq.size() == D);
    check("overflow_cnt", overflow_cnt, m_ovf);
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_vals(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      a0_in = base + W'(i);
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; a0_in = '0; capture_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    do_reset();
    check("reset_out_data", out_data, 0);

    // Unprimed capture of a0=0, then no further entries while stable.
    capture_en = 1'b1;
    cycle();
    check("t1_level", level, 1);
    check("t1_data", out_data, 0);
    repeat (3) cycle();
    check("t1_stable_level", level, 1);

    // 5,5,A,3 with sink stalled, then drain in order.
    do_reset();
    capture_en = 1'b1;
    a0_in = 32'h5; cycle(); cycle();
    a0_in = 32'hA; cycle();
    a0_in = 32'h3; cycle();
    check("t2_level", level, 3);
    out_ready = 1'b1;
    check("t2_d0", out_data, 32'h5); cycle();
    check("t2_d1", out_data, 32'hA); cycle();
    check("t2_d2", out_data, 32'h3); cycle();
    check("t2_empty", out_valid, 0);
    out_ready = 1'b0;

    // Ten distinct values into an 8-deep FIFO.
    do_reset();
    capture_en = 1'b1;
    push_vals(10, 32'h11);
    check("t3_level", level, 8);
    check("t3_full", full, 1);
    check("t3_ovf", overflow_cnt, 2);
    check("t3_head", out_data, 32'h11);
    out_ready = 1'b1;
    repeat (8) cycle();
    a0_in = 32'h1A;
    cycle();
    check("t3_no_recapture", level, 0);
    out_ready = 1'b0;

    // Full with simultaneous pop accepts the push; then continuous wrap.
    do_reset();
    capture_en = 1'b1;
    push_vals(8, 32'h100);
    out_ready = 1'b1;
    a0_in = 32'h200;
    cycle();
    check("t4_level", level, 8);
    check("t4_ovf", overflow_cnt, 0);
    check("t4_head", out_data, 32'h101);
    push_vals(20, 32'h300);
    check("t4_wrap_level", level, 8);
    out_ready = 1'b0;

    // Flush with a simultaneous push request keeps the drop count.
    do_reset();
    capture_en = 1'b1;
    push_vals(11, 32'h40);
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0;
    check("t5_level", level, 4);
    check("t5_ovf", overflow_cnt, 3);
    flush = 1'b1;
    a0_in = 32'h77;
    cycle();
    flush = 1'b0;
    check("t5_flush_level", level, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ovf", overflow_cnt, 3);
    cycle();
    check("t5_recapture", out_data, 32'h77);
    check("t5_recapture_level", level, 1);

    // Asynchronous reset mid-cycle with five entries held.
    do_reset();
    capture_en = 1'b1;
    push_vals(10, 32'h500);
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    check("t6_level_pre", level, 5);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_level", level, 0);
    check("t6_async_ovf", overflow_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    a0_in = 32'h600;
    cycle();
    check("t6_resume", out_data, 32'h600);

    // Randomized traffic; a stalled phase drives the drop counter into saturation.
    for (int i = 0; i < 600; i++) begin
      capture_en = ($urandom_range(0, 9) != 0);
      a0_in      = W'($urandom_range(0, 5));
      flush      = ($urandom_range(0, 39) == 0);
      out_ready  = (i < 200) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      cycle();
    end
    flush = 1'b0;
    check("rand_sat_seen", m_ovf, (1 << C) - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
Downstream consumer of the single-cycle core's a0 result output. Detects every change of a0 and queues each new value in a small first-word-fall-through FIFO. A host-side sink (display driver, UART, or testbench) drains the FIFO over a valid/ready handshake. Overflows are counted rather than stalling the core, which cannot be back-pressured.

Parameters:
WIDTH, 32, data width of a0 and of FIFO entries
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 16, width of the saturating overflow counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
a0_in  in  WIDTH  a0 value from the core
capture_en  in  1  enables change detection and capture
flush  in  1  synchronous FIFO clear
out_data  out  WIDTH  head-of-FIFO value; valid only when out_valid=1
out_valid  out  1  FIFO non-empty
out_ready  in  1  sink accepts out_data this cycle
level  out  $clog2(DEPTH)+1  number of occupied entries
full  out  1  level == DEPTH
overflow_cnt  out  CNT_W  number of dropped captures, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr, wr_ptr, level and overflow_cnt clear to 0.
  - last_a0 clears to 0; primed clears to 0.
  - out_valid=0, full=0. out_data is don't-care; drive 0 from a cleared RAM or gate with out_valid.
  - Release of reset is synchronous to clk.
- Change detect:
  - push_req = capture_en & (!primed | a0_in != last_a0).
  - On push_req, last_a0 <= a0_in and primed <= 1, whether or not the entry is stored. A dropped value therefore does not re-trigger.
- Pop: pop = out_valid & out_ready.
- Push acceptance: push = push_req & (!full | pop).
  - Full with a simultaneous pop: the push is accepted.
  - Empty: pop is impossible, so any push_req is accepted.
- Drop: push_req & full & !pop -> overflow_cnt += 1, saturating at 2^CNT_W-1.
- Storage:
  - On push: mem[wr_ptr] <= a0_in; wr_ptr increments modulo DEPTH.
  - On pop: rd_ptr increments modulo DEPTH.
  - level += push - pop.
- Latency: a value captured at edge N appears on out_data with out_valid=1 immediately after edge N (one cycle, first-word-fall-through). out_data = mem[rd_ptr], combinational from registered state.
- Handshake: once out_valid=1, out_data holds stable until popped; flush and reset are the only exceptions. out_valid never depends combinationally on out_ready.
- Flush (synchronous, highest priority):
  - Pointers and level go to 0; primed goes to 0, so the next enabled cycle recaptures the current a0.
  - overflow_cnt is NOT cleared.
  - Any push or pop in the same cycle is ignored.
- capture_en=0: no captures; last_a0 and primed hold; draining continues.
- Pointer wrap: ptrs are $clog2(DEPTH) bits and wrap naturally. full and empty derive from level, not pointer compare.
- Reset mid-transfer: all contents are lost; out_valid falls asynchronously.

Test Plan:
- Reset then capture_en=1, a0_in=0 held -> one entry 0x0 (unprimed capture), out_valid=1 next cycle, level=1; no further entries while a0 is stable.
- a0_in sequence 0x5, 0x5, 0xA, 0x3 (one per cycle), out_ready=0 -> level=3 (0x5 primed capture, 0xA, 0x3); drain with out_ready=1 -> out_data 0x5, 0xA, 0x3 in order, then out_valid=0.
- out_ready=0, 10 distinct values -> level=8, full=1, overflow_cnt=2; stored values are the first 8; after draining, feeding the last dropped value again produces no capture.
- Full FIFO, out_ready=1 and a new distinct a0 in the same cycle -> level stays 8, overflow_cnt unchanged, new value at tail; run 20 cycles of continuous push/pop to exercise pointer wrap with in-order data.
- level=4, overflow_cnt=3, assert flush with a simultaneous push_req -> level=0, out_valid=0, overflow_cnt=3; next cycle the current a0 is captured (primed cleared).
- Assert rst=0 asynchronously mid-cycle with level=5 -> out_valid=0 and level=0 before the next edge; overflow_cnt=0; capture resumes after release.
